muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port input1  input  32  multiplicand / dividend (rs).
REQ-007 SHALL have port input2  input  32  multiplier / divisor (rt).
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  registered one-cycle pulse; hi/lo are valid from this cycle on.
REQ-010 SHALL have port div_by_zero  output  1  registered; set with done when a DIV/DIVU had input2==0, cleared on next accepted start.
REQ-011 SHALL have port hi  output  32  product[63:32] or remainder.
REQ-012 SHALL have port lo  output  32  product[31:0] or quotient.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-014 SHALL capture input1, input2 and op on the edge E0 where start=1 in IDLE; operand changes afterwards SHALL have no effect.
REQ-015 SHALL perform one iteration per edge E1..E32 in RUN (5-bit counter 0..31): shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-016 SHALL apply sign correction on edge E33 (FIX) and write hi/lo on that edge; done SHALL be high in the cycle after E33 only.
REQ-017 SHALL, for signed MULT, produce the exact 64-bit two's-complement product; MULTU the exact unsigned product.
REQ-018 SHALL, for signed DIV, truncate quotient toward zero, remainder takes dividend sign; 0x80000000 / -1 SHALL give lo=0x80000000, hi=0.
REQ-019 SHALL, for DIV/DIVU with input2==0 at E0, skip RUN, go to FIX, and set lo=32'hFFFFFFFF, hi=input1, div_by_zero=1, done after E1.
REQ-020 SHALL ignore start while busy; no queuing, no effect on the running operation.
REQ-021 SHALL hold hi/lo unchanged from one done to the next write; start in the done cycle SHALL be accepted (state is IDLE).
REQ-022 SHALL keep busy low and done low in the same cycle (done asserts in IDLE).

Reset
REQ-023 SHALL, on reset assertion at any time, immediately force state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0, aborting any operation.
REQ-024 SHALL accept a start on the first rising edge after reset deasserts.

Structure
REQ-025 SHALL place op encodings, state encoding and ITER=32 in shared package muldiv_pkg, used by the control decoder and bench.
REQ-026 SHALL be a single module; no sub-module is required (counter, 64-bit shift register and sign logic inline).

Verification
REQ-027 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done after 34 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 DIVU 100/5 -> lo=20, hi=0, div_by_zero=0; DIV 100/0 -> done 2 cycles after start, lo=0xFFFFFFFF, hi=100, div_by_zero=1.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, no hang.
REQ-031 start pulsed at cycle 10 of a running MULT with new operands -> result equals first operation only; busy stays high through E33.
REQ-032 reset asserted mid-RUN (counter=15) -> busy, done, hi, lo all 0 without waiting for a clock edge; next start runs a full 34-cycle operation correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and iteration count for the multiply/divide unit
package muldiv_pkg;
  localparam int ITER = 32;
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle signed/unsigned multiply and restoring divide with sign fix-up
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_n, p_fix;
  logic [WIDTH-1:0] b, a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] mul_sum, div_diff;
  logic sa, sb, is_div, dz;
  logic signed_in, div_in, a_neg, b_neg, dz_in;
  assign busy      = state != IDLE;
  assign signed_in = op_e'(op) == OP_MULT || op_e'(op) == OP_DIV;
  assign div_in    = op_e'(op) == OP_DIV || op_e'(op) == OP_DIVU;
  assign a_neg     = signed_in & input1[WIDTH-1];
  assign b_neg     = signed_in & input2[WIDTH-1];
  assign a_mag     = a_neg ? -input1 : input1;
  assign b_mag     = b_neg ? -input2 : input2;
  assign dz_in     = div_in && input2 == '0;
  // multiply shifts right through the low half; divide shifts left, quotient bits enter at bit 0
  assign mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
  assign div_diff  = p[2*WIDTH-1:WIDTH-1] - {1'b0, b};
  assign p_n       = !is_div ? {mul_sum, p[WIDTH-1:1]} :
                     div_diff[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} :
                     {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign p_fix     = (sa ^ sb) ? -p : p;
  assign q_fix     = (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign r_fix     = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? (dz_in ? FIX : RUN) :
              (state == RUN && cnt == CW'(ITER - 1)) ? FIX :
              (state == FIX) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      b           <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state <= state_n;
      done  <= state == FIX;
      if (state == IDLE && start) begin
        // a zero divisor keeps the raw dividend so it can be returned in hi
        p           <= {{WIDTH{1'b0}}, dz_in ? input1 : a_mag};
        b           <= b_mag;
        sa          <= a_neg;
        sb          <= b_neg;
        is_div      <= div_in;
        dz          <= dz_in;
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end
      if (state == RUN) begin
        p   <= p_n;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        {hi, lo}    <= dz ? {p[WIDTH-1:0], {WIDTH{1'b1}}} : is_div ? {r_fix, q_fix} : p_fix;
        div_by_zero <= dz;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench comparing muldiv_unit results against a 64-bit arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb_q[$];
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .input1(input1), .input2(input2), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint x, y;
    logic [63:0] u;
    x = longint'($signed(a));
    y = longint'($signed(b));
    e.dbz = 1'b0;
    e.lat = 34;
    if (o[1] && b == 0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
      e.lat = 2;
      return e;
    end
    case (o)
      OP_MULT:  begin u = x * y; e.hi = u[63:32]; e.lo = u[31:0]; end
      OP_MULTU: begin u = {32'b0, a} * {32'b0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
      OP_DIV:   begin u = x / y; e.lo = u[31:0]; u = x % y; e.hi = u[31:0]; end
      default:  begin e.lo = a / b; e.hi = a % b; end
    endcase
    return e;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit intrude);
    int k, n;
    exp_t e;
    start = 1'b1; op = o; input1 = a; input2 = b;
    sb_q.push_back(model(o, a, b));
    k = cyc;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); input1 = $urandom; input2 = $urandom;
    n = 1;
    while (!done && n < 60) begin
      if (intrude) begin
        check("busy_run", busy, 1);
        start = n == 10;
        if (n == 10) begin op = OP_MULTU; input1 = 32'h1234_5678; input2 = 32'h9ABC_DEF0; end
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    check("done", done, 1);
    check("hi", hi, e.hi);
    check("lo", lo, e.lo);
    check("div_by_zero", div_by_zero, e.dbz);
    check("latency", cyc - k, e.lat);
    check("busy_at_done", busy, 0);
  endtask
  initial begin
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_hi_lit", hi, 32'hFFFF_FFFE);
    check("multu_lo_lit", lo, 32'h0000_0001);
    run_op(OP_MULT, -32'sd7, 32'd3, 0);
    run_op(OP_DIV, -32'sd7, 32'd2, 0);
    check("div_lo_lit", lo, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd5, 0);
    run_op(OP_DIV, 32'd100, 32'd0, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo_lit", lo, 32'h8000_0000);
    run_op(OP_MULT, 32'h8765_4321, 32'h0FED_CBA9, 1);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : (i[0] ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op(2'(i), ra, rb, 0);
    end
    start = 1'b1; op = OP_MULT; input1 = 32'd12345; input2 = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULT, -32'sd12345, 32'd678, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
